// File: rtl/add_sub_cmd_sequencer.sv
// ============================================================================
//  Module  : add_sub_cmd_sequencer
//  Brief   : Command FIFO + issue FSM in front of add_sub_8bit; returns
//            Z/Overflow/Carryout on a valid/ready response port.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module add_sub_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic                     cmd_sel,
  input  logic                     cmd_addsub,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic                     alu_sel,
  output logic                     alu_addsub,
  input  logic [7:0]               alu_z,
  input  logic                     alu_overflow,
  input  logic                     alu_carryout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_z,
  output logic                     rsp_overflow,
  output logic                     rsp_carry,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_LW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [c_AW-1:0] c_PTR_ONE = 1;
  localparam logic [c_CW-1:0] c_CNT_ONE = 1;
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_LW-1:0] c_LAT     = c_LW'(ALU_LAT);
  localparam logic [c_LW-1:0] c_LAT_ONE = 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [17:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [1:0]      r_state;
  logic [c_LW-1:0] r_wcnt;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [17:0]     w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL);
  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && !w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign busy       = (r_state != c_IDLE);

  // Pop only when the FSM is about to issue; one op in flight at a time.
  assign w_pop = !w_empty &&
                 ((r_state == c_IDLE) || ((r_state == c_HOLD) && rsp_ready));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_sel, cmd_addsub};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_wcnt       <= '0;
      alu_a        <= 8'd0;
      alu_b        <= 8'd0;
      alu_sel      <= 1'b1;
      alu_addsub   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_z        <= 8'd0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
    end else begin
      // HOLD op (Z + 0) unless an issue overrides it below.
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      alu_sel    <= 1'b1;
      alu_addsub <= 1'b0;

      if (w_pop) begin
        {alu_a, alu_b, alu_sel, alu_addsub} <= w_head;
        r_wcnt <= c_LAT;
      end

      case (r_state)
        c_IDLE: begin
          if (w_pop) r_state <= c_WAIT;
        end
        c_WAIT: begin
          // Sampled before the ALU absorbs the HOLD op, so its flags never leak.
          if (r_wcnt == '0) begin
            rsp_z        <= alu_z;
            rsp_overflow <= alu_overflow;
            rsp_carry    <= alu_carryout;
            rsp_valid    <= 1'b1;
            r_state      <= c_HOLD;
          end else begin
            r_wcnt <= r_wcnt - c_LAT_ONE;
          end
        end
        c_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= w_pop ? c_WAIT : c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_sub_cmd_sequencer.sv
// Bench for add_sub_cmd_sequencer: table-driven single ops plus queued,
// backpressure and mid-operation reset sequences against a small ALU model.
`default_nettype none

module tb_add_sub_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic       cmd_sel = 1'b0;
  logic       cmd_addsub = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic       alu_sel, alu_addsub;
  logic [7:0] alu_z;
  logic       alu_overflow, alu_carryout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_z;
  logic       rsp_overflow, rsp_carry;
  logic [2:0] fifo_count;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_sub_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_addsub(cmd_addsub),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_addsub(alu_addsub),
    .alu_z(alu_z), .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .fifo_count(fifo_count), .busy(busy)
  );

  // add_sub_8bit model: one register stage, subtract as A + ~B + 1.
  logic [7:0] m_x, m_bb;
  logic [8:0] m_sum;
  always_comb begin
    m_x   = alu_sel ? alu_z : alu_a;
    m_bb  = alu_addsub ? ~alu_b : alu_b;
    m_sum = {1'b0, m_x} + {1'b0, m_bb} + {8'd0, alu_addsub};
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_z <= 8'd0; alu_overflow <= 1'b0; alu_carryout <= 1'b0;
    end else begin
      alu_z        <= m_sum[7:0];
      alu_carryout <= m_sum[8];
      alu_overflow <= (m_x[7] == m_bb[7]) && (m_sum[7] != m_x[7]);
    end
  end

  typedef struct packed { logic [7:0] z; logic v; logic c; } rsp_t;
  rsp_t got[$];
  int   seen_valid = 0;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) seen_valid <= seen_valid + 1;
    if (rst_n && rsp_valid && rsp_ready) got.push_back({rsp_z, rsp_overflow, rsp_carry});
  end

  typedef struct {
    logic [7:0] a; logic [7:0] b; logic sel; logic addsub;
    logic [7:0] z; logic v; logic c;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sel, input logic addsub);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_addsub = addsub;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 1);
  endtask

  task automatic collect(input int base, input int n);
    int t = 0;
    while (got.size() < base + n && t < 200) begin @(posedge clk); t++; end
    if (got.size() < base + n) chk("collect_timeout", got.size() - base, n);
  endtask

  initial begin
    int   lat, base, acc, sv0;
    logic will_acc;
    rsp_t exp_q[5];

    vecs[0] = '{a:8'd25,  b:8'd10,  sel:1'b0, addsub:1'b0, z:8'd35,  v:1'b0, c:1'b0};
    vecs[1] = '{a:8'd40,  b:8'd15,  sel:1'b0, addsub:1'b1, z:8'd25,  v:1'b0, c:1'b1};
    vecs[2] = '{a:8'd99,  b:8'd5,   sel:1'b1, addsub:1'b0, z:8'd30,  v:1'b0, c:1'b0};
    vecs[3] = '{a:8'd0,   b:8'd3,   sel:1'b1, addsub:1'b1, z:8'd27,  v:1'b0, c:1'b1};
    vecs[4] = '{a:8'd100, b:8'd100, sel:1'b0, addsub:1'b0, z:8'd200, v:1'b1, c:1'b0};
    vecs[5] = '{a:8'd0,   b:8'd100, sel:1'b1, addsub:1'b0, z:8'd44,  v:1'b0, c:1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_alu_sel", 32'(alu_sel), 1);
    chk("reset_alu_a", 32'(alu_a), 0);
    chk("reset_rsp_z", 32'(rsp_z), 0);

    // Single ops, one at a time, each checked for latency and result.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].addsub);
      wait_rsp(lat);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_z", i), 32'(rsp_z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_ovf", i), 32'(rsp_overflow), 32'(vecs[i].v));
      chk($sformatf("vec%0d_carry", i), 32'(rsp_carry), 32'(vecs[i].c));
      chk($sformatf("vec%0d_alu_hold", i), 32'({alu_sel, alu_b}), 32'h100);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid_drop", i), 32'(rsp_valid), 0);
    end

    // Sub then two accumulates queued back-to-back.
    base = got.size();
    send(8'd40, 8'd15, 1'b0, 1'b1);
    send(8'd0,  8'd5,  1'b1, 1'b0);
    send(8'd0,  8'd3,  1'b1, 1'b1);
    collect(base, 3);
    if (got.size() >= base + 3) begin
      chk("chain0_z", 32'(got[base].z), 25);
      chk("chain1_z", 32'(got[base+1].z), 30);
      chk("chain2_z", 32'(got[base+2].z), 27);
      chk("chain2_carry", 32'(got[base+2].c), 1);
    end

    // Backpressure: hold rsp_ready low and push every cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    base = got.size();
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_addsub = 1'b0;
      cmd_a = 8'(10 * acc + 1); cmd_b = 8'(acc);
      will_acc = cmd_ready;
      @(posedge clk);
      if (will_acc) acc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("full_accepted", acc, 5);
    chk("full_cmd_ready", 32'(cmd_ready), 0);
    chk("full_fifo_count", 32'(fifo_count), 4);
    chk("full_rsp_valid", 32'(rsp_valid), 1);
    chk("full_rsp_z", 32'(rsp_z), 1);
    repeat (3) @(negedge clk);
    chk("full_rsp_z_stable", 32'(rsp_z), 1);
    chk("full_rsp_valid_stable", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    collect(base, 5);
    for (int k = 0; k < 5; k++) exp_q[k] = {8'(11 * k + 1), 1'b0, 1'b0};
    if (got.size() >= base + 5)
      for (int k = 0; k < 5; k++) chk($sformatf("drain%0d", k), 32'(got[base+k]), 32'(exp_q[k]));

    // Reset while the first op waits and two more are queued.
    repeat (4) @(posedge clk);
    send(8'd1, 8'd1, 1'b0, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b0);
    send(8'd3, 8'd3, 1'b0, 1'b0);
    chk("prereset_busy", 32'(busy), 1);
    chk("prereset_fifo_count", 32'(fifo_count), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);
    chk("midreset_fifo_count", 32'(fifo_count), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_alu_hold", 32'({alu_a, alu_b, alu_sel, alu_addsub}), 32'h00002);
    base = got.size();
    sv0 = seen_valid;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("postreset_no_rsp", got.size() - base, 0);
    chk("postreset_no_valid", seen_valid - sv0, 0);
    chk("postreset_fifo_count", 32'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
